// File: rtl/mem_arbiter_if.sv
// Bus bundle between the pipeline's fetch/data ports, the arbiter and the unified memory.
// The arbiter takes the slave view; the pipeline plus memory side takes the master view.
interface mem_arbiter_if #(
   parameter int N = 64
);
   logic          if_req;
   logic [31:0]   if_adr;
   logic [31:0]   if_instr;
   logic          if_stall;
   logic          if_done;
   logic          d_req;
   logic [1:0]    d_we;
   logic [N-1:0]  d_adr;
   logic [N-1:0]  d_wdata;
   logic [N-1:0]  d_rdata;
   logic          d_stall;
   logic          d_done;
   logic          m_req;
   logic [1:0]    m_we;
   logic [N-1:0]  m_adr;
   logic [N-1:0]  m_wdata;
   logic [N-1:0]  m_rdata;
   logic          m_ready;

   modport slave (
      input  if_req, if_adr, d_req, d_we, d_adr, d_wdata, m_rdata, m_ready,
      output if_instr, if_stall, if_done, d_rdata, d_stall, d_done,
             m_req, m_we, m_adr, m_wdata
   );

   modport master (
      output if_req, if_adr, d_req, d_we, d_adr, d_wdata, m_rdata, m_ready,
      input  if_instr, if_stall, if_done, d_rdata, d_stall, d_done,
             m_req, m_we, m_adr, m_wdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises instruction-fetch and data accesses onto one single-port memory.
// Data has priority; after MAX_DWIN data wins against a waiting fetch, the fetch goes once.
module mem_arbiter #(
   parameter int N        = 64,
   parameter int MAX_DWIN = 4
) (
   input  logic         clk,
   input  logic         reset,
   mem_arbiter_if.slave bus
);
   localparam int CW = $clog2(MAX_DWIN + 1);

   typedef enum logic [1:0] {IDLE, IFETCH, DACC} state_t;

   state_t         state;
   logic [CW-1:0]  dwin_cnt;
   logic [CW-1:0]  dwin_next;
   logic           m_req_r;
   logic [1:0]     m_we_r;
   logic [N-1:0]   m_adr_r;
   logic [N-1:0]   m_wdata_r;
   logic           if_done_r;
   logic           d_done_r;
   logic [31:0]    if_instr_r;
   logic [N-1:0]   d_rdata_r;
   logic           fetch_due;
   logic           bubble;
   logic           grant_d;
   logic           grant_i;

   // Selects the 32-bit instruction from the bus word by address bit 2 on a wide bus.
   function automatic logic [31:0] fetch_word(input logic [N-1:0] w, input logic hi);
      logic [N-1:0] s;
      s = (N > 32 && hi) ? (w >> 32) : w;
      return s[31:0];
   endfunction

   // A done pulse forces one idle bubble so the pipeline can present its next request.
   always_comb begin
      fetch_due = bus.if_req && (dwin_cnt == CW'(MAX_DWIN));
      bubble    = if_done_r || d_done_r;
      grant_d   = !bubble && bus.d_req && !fetch_due;
      grant_i   = !bubble && bus.if_req && !grant_d;
      dwin_next = (dwin_cnt == CW'(MAX_DWIN)) ? dwin_cnt : dwin_cnt + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         dwin_cnt   <= '0;
         m_req_r    <= 1'b0;
         m_we_r     <= 2'b00;
         m_adr_r    <= '0;
         m_wdata_r  <= '0;
         if_done_r  <= 1'b0;
         d_done_r   <= 1'b0;
         if_instr_r <= '0;
         d_rdata_r  <= '0;
      end else begin
         if_done_r <= 1'b0;
         d_done_r  <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_d) begin
                  state     <= DACC;
                  m_req_r   <= 1'b1;
                  m_we_r    <= bus.d_we;
                  m_adr_r   <= bus.d_adr;
                  m_wdata_r <= bus.d_wdata;
                  dwin_cnt  <= bus.if_req ? dwin_next : '0;
               end else if (grant_i) begin
                  state     <= IFETCH;
                  m_req_r   <= 1'b1;
                  m_we_r    <= 2'b00;
                  m_adr_r   <= N'(bus.if_adr);
                  m_wdata_r <= '0;
                  dwin_cnt  <= '0;
               end
            end
            // The access always completes, even if the requester has since dropped out.
            IFETCH, DACC: begin
               if (bus.m_ready) begin
                  state   <= IDLE;
                  m_req_r <= 1'b0;
                  if (state == DACC) begin
                     d_rdata_r <= bus.m_rdata;
                     d_done_r  <= 1'b1;
                  end else begin
                     if_instr_r <= fetch_word(bus.m_rdata, m_adr_r[2]);
                     if_done_r  <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.m_req    = m_req_r;
   assign bus.m_we     = m_we_r;
   assign bus.m_adr    = m_adr_r;
   assign bus.m_wdata  = m_wdata_r;
   assign bus.if_done  = if_done_r;
   assign bus.d_done   = d_done_r;
   assign bus.if_instr = if_instr_r;
   assign bus.d_rdata  = d_rdata_r;
   assign bus.if_stall = bus.if_req & ~if_done_r;
   assign bus.d_stall  = bus.d_req & ~d_done_r;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
   localparam int N    = 64;
   localparam int MAXD = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_arbiter_if #(.N(N)) bus ();
   mem_arbiter #(.N(N), .MAX_DWIN(MAXD)) dut (.clk(clk), .reset(reset), .bus(bus));

   int vectors = 0;
   int miscompares = 0;
   bit chk_on = 0;

   // model of the arbiter: what is in flight, who owns it, fetch streak
   bit          busy, owner_d, e_m_req, e_if_done, e_d_done;
   logic [1:0]  e_m_we;
   logic [63:0] e_m_adr, e_m_wdata, e_d_rdata;
   logic [31:0] e_if_instr;
   int          streak;
   string       gstr;

   // memory responder controls
   int          mcnt, cur_lat, lat_cfg;
   bit          stray, use_fixed;
   logic [63:0] fixed_rdata;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_str(input string name, input string act, input string exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %s expected %s", name, act, exp);
      end
   endtask

   task automatic model_step();
      bit bubble, take_d;
      if (reset) begin
         busy = 0; owner_d = 0; e_m_req = 0; e_m_we = 0; e_m_adr = 0; e_m_wdata = 0;
         e_if_done = 0; e_d_done = 0; e_if_instr = 0; e_d_rdata = 0; streak = 0;
         return;
      end
      bubble = e_if_done | e_d_done;
      e_if_done = 0;
      e_d_done = 0;
      if (busy) begin
         if (bus.m_ready) begin
            busy = 0;
            e_m_req = 0;
            if (owner_d) begin
               e_d_rdata = bus.m_rdata;
               e_d_done = 1;
            end else begin
               e_if_instr = 32'(bus.m_rdata >> (e_m_adr[2] ? 32 : 0));
               e_if_done = 1;
            end
         end
      end else if (!bubble && (bus.if_req || bus.d_req)) begin
         take_d = bus.d_req && !(bus.if_req && streak >= MAXD);
         busy = 1;
         e_m_req = 1;
         owner_d = take_d;
         if (take_d) begin
            e_m_we = bus.d_we;
            e_m_adr = bus.d_adr;
            e_m_wdata = bus.d_wdata;
            gstr = {gstr, "D"};
            streak = bus.if_req ? ((streak + 1 > MAXD) ? MAXD : streak + 1) : 0;
         end else begin
            e_m_we = 2'b00;
            e_m_adr = {32'h0, bus.if_adr};
            e_m_wdata = 0;
            gstr = {gstr, "I"};
            streak = 0;
         end
      end
   endtask

   always @(posedge clk) model_step();

   task automatic compare_all();
      chk("m_req", 64'(bus.m_req), 64'(e_m_req));
      chk("m_we", 64'(bus.m_we), 64'(e_m_we));
      chk("m_adr", bus.m_adr, e_m_adr);
      chk("m_wdata", bus.m_wdata, e_m_wdata);
      chk("if_done", 64'(bus.if_done), 64'(e_if_done));
      chk("d_done", 64'(bus.d_done), 64'(e_d_done));
      chk("if_instr", 64'(bus.if_instr), 64'(e_if_instr));
      chk("d_rdata", bus.d_rdata, e_d_rdata);
      chk("if_stall", 64'(bus.if_stall), 64'(bus.if_req & ~e_if_done));
      chk("d_stall", 64'(bus.d_stall), 64'(bus.d_req & ~e_d_done));
   endtask

   always @(negedge clk) if (chk_on) compare_all();

   task automatic tick();
      @(posedge clk);
      #1;
      if (e_m_req) begin
         if (mcnt == 0) cur_lat = (lat_cfg > 0) ? lat_cfg : int'($urandom_range(1, 5));
         mcnt++;
         bus.m_ready = (mcnt == cur_lat);
         bus.m_rdata = (bus.m_ready && use_fixed) ? fixed_rdata : {$urandom, $urandom};
      end else begin
         mcnt = 0;
         bus.m_ready = stray;
         stray = 0;
         bus.m_rdata = {$urandom, $urandom};
      end
   endtask

   task automatic do_reset();
      reset = 1;
      bus.if_req = 0;
      bus.d_req = 0;
      tick();
      reset = 0;
   endtask

   initial begin
      int nreq, ndone, lost, n, done_at, fetch_at, dpulses, store_req;
      bit bad_we;
      logic [31:0] instr;
      logic [63:0] st_adr;
      reset = 1;
      bus.if_req = 0; bus.if_adr = 0; bus.d_req = 0; bus.d_we = 0;
      bus.d_adr = 0; bus.d_wdata = 0; bus.m_rdata = 0; bus.m_ready = 0;
      lat_cfg = 0; stray = 0; use_fixed = 0; fixed_rdata = 0; mcnt = 0; cur_lat = 1;
      gstr = "";
      tick();
      chk_on = 1;
      do_reset();

      chk("rst_m_req", 64'(bus.m_req), 64'd0);
      chk("rst_if_done", 64'(bus.if_done), 64'd0);
      chk("rst_d_done", 64'(bus.d_done), 64'd0);
      chk("rst_if_instr", 64'(bus.if_instr), 64'd0);
      chk("rst_d_rdata", bus.d_rdata, 64'd0);
      chk("rst_m_adr", bus.m_adr, 64'd0);

      // single fetch, latency 3, upper word selected by address bit 2
      lat_cfg = 3; use_fixed = 1; fixed_rdata = 64'h1111_2222_3333_4444;
      bus.if_req = 1; bus.if_adr = 32'h0000_0004;
      nreq = 0; ndone = 0; bad_we = 0; instr = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.m_req) begin
            nreq++;
            if (bus.m_we != 2'b00) bad_we = 1;
         end
         if (bus.if_done) begin
            ndone++;
            instr = bus.if_instr;
            bus.if_req = 0;
         end
      end
      chk("t1_mreq_cycles", 64'(nreq), 64'd3);
      chk("t1_done_pulses", 64'(ndone), 64'd1);
      chk("t1_instr", 64'(instr), 64'h1111_2222);
      chk("t1_model_instr", 64'(e_if_instr), 64'h1111_2222);
      chk("t1_m_we", 64'(bad_we), 64'd0);
      use_fixed = 0;

      // simultaneous load and fetch: data first, fetch decided the cycle after d_done
      do_reset();
      lat_cfg = 2;
      bus.d_req = 1; bus.d_we = 2'b00; bus.d_adr = 64'h40;
      bus.if_req = 1; bus.if_adr = 32'h100;
      tick();
      chk("t2_first_adr", bus.m_adr, 64'h40);
      chk("t2_if_stall", 64'(bus.if_stall), 64'd1);
      n = 0; lost = 0;
      while (!bus.d_done && n < 20) begin
         tick();
         n++;
         if (!bus.if_stall) lost++;
      end
      chk("t2_d_done_seen", 64'(bus.d_done), 64'd1);
      chk("t2_if_stall_held", 64'(lost), 64'd0);
      bus.d_req = 0;
      tick();
      chk("t2_gap_m_req", 64'(bus.m_req), 64'd0);
      tick();
      chk("t2_fetch_m_req", 64'(bus.m_req), 64'd1);
      chk("t2_fetch_adr", bus.m_adr, 64'h100);
      n = 0;
      while (!bus.if_done && n < 20) begin
         tick();
         n++;
      end
      chk("t2_if_done_seen", 64'(bus.if_done), 64'd1);
      bus.if_req = 0;

      // back-to-back stores against a waiting fetch: starvation limit
      do_reset();
      lat_cfg = 0; gstr = "";
      bus.if_req = 1; bus.if_adr = $urandom & 32'hFFFF_FFFC;
      bus.d_req = 1; bus.d_we = 2'b01; bus.d_adr = {$urandom, $urandom}; bus.d_wdata = {$urandom, $urandom};
      for (int i = 0; i < 300 && gstr.len() < 10; i++) begin
         tick();
         if (e_d_done) begin
            bus.d_we = 2'($urandom_range(1, 2));
            bus.d_adr = {$urandom, $urandom};
            bus.d_wdata = {$urandom, $urandom};
         end
         if (e_if_done) bus.if_adr = $urandom & 32'hFFFF_FFFC;
      end
      chk_str("t3_grants", gstr, "DDDDIDDDDI");
      bus.d_req = 0; bus.if_req = 0;
      repeat (12) tick();

      // stray m_ready while idle
      stray = 1;
      tick();
      tick();
      chk("t4_if_done", 64'(bus.if_done), 64'd0);
      chk("t4_d_done", 64'(bus.d_done), 64'd0);
      chk("t4_m_req", 64'(bus.m_req), 64'd0);
      tick();
      chk("t4_if_instr", 64'(bus.if_instr), 64'(e_if_instr));

      // reset one cycle into a 5-cycle store
      do_reset();
      lat_cfg = 5;
      bus.d_req = 1; bus.d_we = 2'b10; bus.d_adr = 64'h88; bus.d_wdata = 64'hDEAD_BEEF_0123_4567;
      tick();
      chk("t5_m_req_on", 64'(bus.m_req), 64'd1);
      reset = 1; bus.d_req = 0;
      tick();
      reset = 0;
      chk("t5_m_req_off", 64'(bus.m_req), 64'd0);
      stray = 1;
      ndone = 0;
      repeat (6) begin
         tick();
         if (bus.d_done) ndone++;
      end
      chk("t5_no_d_done", 64'(ndone), 64'd0);

      // store flushed after grant: still completes, fetch follows one cycle after done
      do_reset();
      lat_cfg = 3;
      st_adr = 64'h0000_0000_0000_1230;
      bus.d_req = 1; bus.d_we = 2'b01; bus.d_adr = st_adr; bus.d_wdata = 64'h5555_AAAA_5555_AAAA;
      tick();
      chk("t6_granted", 64'(bus.m_req), 64'd1);
      bus.d_req = 0; bus.if_req = 1; bus.if_adr = 32'h200;
      done_at = -1; fetch_at = -1; dpulses = 0; store_req = 1;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus.m_req && bus.m_adr == st_adr) store_req++;
         if (bus.d_done) begin
            dpulses++;
            if (done_at < 0) done_at = i;
         end
         if (bus.m_req && bus.m_adr == 64'h200 && fetch_at < 0) fetch_at = i;
         if (bus.if_done) bus.if_req = 0;
      end
      chk("t6_store_req_cycles", 64'(store_req), 64'd3);
      chk("t6_d_done_pulses", 64'(dpulses), 64'd1);
      chk("t6_fetch_gap", 64'(fetch_at - done_at), 64'd2);

      // randomised traffic with flushes, stray m_ready and rare resets
      do_reset();
      lat_cfg = 0;
      for (int i = 0; i < 3000; i++) begin
         tick();
         reset = ($urandom_range(0, 499) == 0);
         if (!(bus.if_req && !e_if_done)) begin
            bus.if_req = ($urandom_range(0, 9) < 7);
            bus.if_adr = $urandom & 32'hFFFF_FFFC;
         end else if ($urandom_range(0, 99) == 0) begin
            bus.if_req = 0;
         end
         if (!(bus.d_req && !e_d_done)) begin
            bus.d_req = ($urandom_range(0, 9) < 6);
            bus.d_we = 2'($urandom_range(0, 2));
            bus.d_adr = {$urandom, $urandom};
            bus.d_wdata = {$urandom, $urandom};
         end else if ($urandom_range(0, 99) == 0) begin
            bus.d_req = 0;
         end
         if (!busy && $urandom_range(0, 19) == 0) stray = 1;
      end
      reset = 0; bus.if_req = 0; bus.d_req = 0;
      repeat (10) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
